// File: rtl/switch_pkg.sv
// Shared constants for the Minisys-1 DIP-switch controller: register map,
// control bit positions and switch bank width.
package switch_pkg;

    localparam int SW_W = 24;

    localparam logic [2:0] REG_STAT_LO = 3'd0;
    localparam logic [2:0] REG_STAT_HI = 3'd1;
    localparam logic [2:0] REG_PEND_LO = 3'd2;
    localparam logic [2:0] REG_PEND_HI = 3'd3;
    localparam logic [2:0] REG_MASK_LO = 3'd4;
    localparam logic [2:0] REG_MASK_HI = 3'd5;
    localparam logic [2:0] REG_CTRL    = 3'd6;
    localparam logic [2:0] REG_RSVD    = 3'd7;

    localparam int CTRL_IE     = 0;
    localparam int CTRL_FREEZE = 1;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus whole-vector debouncer. Publishes the stable
// switch image and a same-cycle commit strobe with the bits about to change.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [SW_W-1:0] i_sw,
    input  logic            i_freeze,
    output logic [SW_W-1:0] o_stable,
    output logic            o_commit,
    output logic [SW_W-1:0] o_change
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [SW_W-1:0]  r_s1;
    logic [SW_W-1:0]  r_s2;
    logic [SW_W-1:0]  r_cand;
    logic [SW_W-1:0]  r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic w_settled;
    logic w_commit;

    // The commit is combinational so the top can set pending bits on the
    // very edge that updates the stable image.
    assign w_settled = (r_cnt == CNT_MAX);
    assign w_commit  = w_settled && (r_cand != r_stable) && !i_freeze;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1     <= '0;
            r_s2     <= '0;
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_s1   <= i_sw;
            r_s2   <= r_s1;
            r_cand <= r_s2;
            if (r_s2 != r_cand) begin
                r_cnt <= '0;
            end else if (!w_settled) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_commit) begin
                r_stable <= r_cand;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_commit = w_commit;
    assign o_change = r_cand ^ r_stable;

endmodule

// File: rtl/switch_ctrl.sv
// Memory-mapped DIP-switch controller: register file, bus interface and
// maskable change interrupt around the debouncer.
module switch_ctrl
    import switch_pkg::*;
#(
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = 15
) (
    input  logic            switclk,
    input  logic            switrst,
    input  logic [SW_W-1:0] switch_i,
    input  logic            switchcs,
    input  logic            switchread,
    input  logic            switchwrite,
    input  logic [2:0]      switchaddr,
    input  logic [15:0]     switchwdata,
    output logic [15:0]     switchrdata,
    output logic            switchirq
);

    logic [SW_W-1:0] w_stable;
    logic [SW_W-1:0] w_change;
    logic            w_commit;
    logic            w_wr;
    logic            w_rd;
    logic [SW_W-1:0] w_w1c;
    logic [SW_W-1:0] w_pending_nxt;
    logic [15:0]     w_rd_mux;

    logic [SW_W-1:0] r_pending;
    logic [SW_W-1:0] r_mask;
    logic [1:0]      r_ctrl;
    logic [15:0]     r_rdata;
    logic            r_irq;

    switch_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_debounce (
        .i_clk    (switclk),
        .i_rst    (switrst),
        .i_sw     (switch_i),
        .i_freeze (r_ctrl[CTRL_FREEZE]),
        .o_stable (w_stable),
        .o_commit (w_commit),
        .o_change (w_change)
    );

    assign w_wr = switchcs && switchwrite;
    assign w_rd = switchcs && switchread;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_w1c = '0;
        if (w_wr) begin
            case (switchaddr)
                REG_PEND_LO: w_w1c[15:0]  = switchwdata;
                REG_PEND_HI: w_w1c[23:16] = switchwdata[7:0];
                default:     w_w1c        = '0;
            endcase
        end
    end

    // A fresh change event wins over a W1C hitting the same bit.
    assign w_pending_nxt = (r_pending & ~w_w1c) | (w_commit ? w_change : '0);

    always_comb begin
        w_rd_mux = 16'h0000;
        case (switchaddr)
            REG_STAT_LO: w_rd_mux = w_stable[15:0];
            REG_STAT_HI: w_rd_mux = {8'h00, w_stable[23:16]};
            REG_PEND_LO: w_rd_mux = r_pending[15:0];
            REG_PEND_HI: w_rd_mux = {8'h00, r_pending[23:16]};
            REG_MASK_LO: w_rd_mux = r_mask[15:0];
            REG_MASK_HI: w_rd_mux = {8'h00, r_mask[23:16]};
            REG_CTRL:    w_rd_mux = {14'h0000, r_ctrl};
            REG_RSVD:    w_rd_mux = 16'h0000;
            default:     w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge switclk or posedge switrst) begin
        if (switrst) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_ctrl    <= '0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr) begin
                case (switchaddr)
                    REG_MASK_LO: r_mask[15:0]  <= switchwdata;
                    REG_MASK_HI: r_mask[23:16] <= switchwdata[7:0];
                    REG_CTRL:    r_ctrl        <= switchwdata[1:0];
                    default:     ;
                endcase
            end
            // The read mux sees pre-write register values on this edge.
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
            r_irq <= r_ctrl[CTRL_IE] && |(r_pending & r_mask);
        end
    end

    assign switchrdata = r_rdata;
    assign switchirq   = r_irq;

endmodule

// File: tb/tb_switch_ctrl.sv
// Bench for switch_ctrl with a short debounce window: register tables,
// directed multi-cycle sequences and a randomized run against a window model.
module tb_switch_ctrl;
    import switch_pkg::*;

    localparam int DEB = 4;
    localparam int CW  = 3;

    logic        switclk;
    logic        switrst;
    logic [23:0] switch_i;
    logic        switchcs;
    logic        switchread;
    logic        switchwrite;
    logic [2:0]  switchaddr;
    logic [15:0] switchwdata;
    logic [15:0] switchrdata;
    logic        switchirq;

    switch_ctrl #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .switclk     (switclk),
        .switrst     (switrst),
        .switch_i    (switch_i),
        .switchcs    (switchcs),
        .switchread  (switchread),
        .switchwrite (switchwrite),
        .switchaddr  (switchaddr),
        .switchwdata (switchwdata),
        .switchrdata (switchrdata),
        .switchirq   (switchirq)
    );

    initial begin
        switclk = 1'b0;
        forever #5 switclk = ~switclk;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_irq(input string name, input logic exp);
        check(name, {15'd0, switchirq}, {15'd0, exp});
    endtask

    // Reference model: a commit happens when the last DEB values seen by the
    // debouncer window (input samples delayed by the synchroniser) all agree
    // and differ from the published image.
    logic [23:0] hist[$];
    logic [23:0] m_stable, m_pend, m_mask;
    logic [1:0]  m_ctrl;
    logic [15:0] m_rdata;
    logic        m_irq;

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_stable[15:0];
            3'd1:    return {8'h00, m_stable[23:16]};
            3'd2:    return m_pend[15:0];
            3'd3:    return {8'h00, m_pend[23:16]};
            3'd4:    return m_mask[15:0];
            3'd5:    return {8'h00, m_mask[23:16]};
            3'd6:    return {14'd0, m_ctrl};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_stable = '0; m_pend = '0; m_mask = '0; m_ctrl = '0;
        m_rdata = '0;  m_irq = 1'b0;
        hist.delete();
        for (int i = 0; i < DEB + 3; i++) hist.push_back(24'd0);
    endtask

    task automatic model_edge(input logic rd, input logic wr, input logic [2:0] a,
                              input logic [15:0] wd, input logic [23:0] sw);
        logic        same;
        logic [23:0] x, chg, w1c, nxt_mask;
        logic [1:0]  nxt_ctrl;
        hist.push_back(sw);
        void'(hist.pop_front());
        x = hist[0];
        same = 1'b1;
        for (int i = 1; i < DEB; i++) if (hist[i] != x) same = 1'b0;
        chg = (same && x != m_stable && !m_ctrl[1]) ? (x ^ m_stable) : 24'd0;
        w1c = '0; nxt_mask = m_mask; nxt_ctrl = m_ctrl;
        if (wr) begin
            case (a)
                3'd2: w1c[15:0] = wd;
                3'd3: w1c[23:16] = wd[7:0];
                3'd4: nxt_mask[15:0] = wd;
                3'd5: nxt_mask[23:16] = wd[7:0];
                3'd6: nxt_ctrl = wd[1:0];
                default: ;
            endcase
        end
        if (rd) m_rdata = m_read(a);
        m_irq    = m_ctrl[0] && |(m_pend & m_mask);
        m_pend   = (m_pend & ~w1c) | chg;
        m_stable = m_stable ^ chg;
        m_mask   = nxt_mask;
        m_ctrl   = nxt_ctrl;
    endtask

    task automatic cyc(input logic rd, input logic wr, input logic [2:0] a, input logic [15:0] wd);
        switchcs = rd | wr; switchread = rd; switchwrite = wr;
        switchaddr = a; switchwdata = wd;
        @(posedge switclk);
        model_edge(rd, wr, a, wd, switch_i);
        #1;
        switchcs = 1'b0; switchread = 1'b0; switchwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [15:0] wd);
        cyc(1'b0, 1'b1, a, wd);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [15:0] exp);
        cyc(1'b1, 1'b0, a, 16'h0);
        check(name, switchrdata, exp);
    endtask

    task automatic do_reset();
        switrst = 1'b1;
        switchcs = 1'b0; switchread = 1'b0; switchwrite = 1'b0;
        repeat (2) @(posedge switclk);
        model_reset();
        #1 switrst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t tbl_rst[8];
    rd_vec_t tbl_a5[8];

    initial begin
        logic        r_b, w_b;
        logic [2:0]  a;
        logic [15:0] wd;

        for (int i = 0; i < 8; i++) tbl_rst[i] = '{3'(i), 16'h0000};
        tbl_a5[0] = '{3'd0, 16'h1234};
        tbl_a5[1] = '{3'd1, 16'h00A5};
        tbl_a5[2] = '{3'd2, 16'h1234};
        tbl_a5[3] = '{3'd3, 16'h00A5};
        tbl_a5[4] = '{3'd4, 16'h0000};
        tbl_a5[5] = '{3'd5, 16'h0000};
        tbl_a5[6] = '{3'd6, 16'h0000};
        tbl_a5[7] = '{3'd7, 16'h0000};

        switrst = 1'b1; switch_i = '0;
        switchcs = 1'b0; switchread = 1'b0; switchwrite = 1'b0;
        switchaddr = '0; switchwdata = '0;
        do_reset();

        // Reset state
        chk_irq("rst_irq", 1'b0);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("rst_rd%0d", i), tbl_rst[i].addr, tbl_rst[i].exp);

        // Clean step commits exactly on the DEB+3rd edge
        switch_i = 24'hA5_1234;
        idle(DEB + 2);
        rd_chk("step_edge7_old", REG_STAT_LO, 16'h0000);
        rd_chk("step_edge8_new", REG_STAT_LO, 16'h1234);
        for (int i = 0; i < 8; i++) rd_chk($sformatf("a5_rd%0d", i), tbl_a5[i].addr, tbl_a5[i].exp);
        chk_irq("a5_irq_masked", 1'b0);

        // Glitch shorter than the window
        switch_i[0] = 1'b1;
        idle(DEB - 1);
        switch_i[0] = 1'b0;
        idle(10);
        rd_chk("glitch_stable", REG_STAT_LO, 16'h1234);
        rd_chk("glitch_pend", REG_PEND_LO, 16'h1234);
        wr_reg(REG_PEND_LO, 16'hFFFF);
        wr_reg(REG_PEND_HI, 16'h00FF);
        rd_chk("w1c_lo", REG_PEND_LO, 16'h0000);
        rd_chk("w1c_hi", REG_PEND_HI, 16'h0000);

        // Interrupt through mask and enable
        wr_reg(REG_MASK_LO, 16'h0001);
        wr_reg(REG_CTRL, 16'h0001);
        switch_i = 24'hA5_1235;
        idle(10);
        chk_irq("irq_set", 1'b1);
        wr_reg(REG_PEND_LO, 16'h0001);
        chk_irq("irq_w1c_edge", 1'b1);
        idle(1);
        chk_irq("irq_cleared", 1'b0);
        switch_i = 24'hA5_1215;
        idle(10);
        chk_irq("irq_unmasked_bit", 1'b0);
        rd_chk("pend_bit5", REG_PEND_LO, 16'h0020);

        // Commit and W1C on the same edge: set wins
        switch_i = 24'hA5_121D;
        idle(DEB + 2);
        wr_reg(REG_PEND_LO, 16'h0008);
        rd_chk("set_wins", REG_PEND_LO, 16'h0028);

        // Freeze holds the image; commit on the edge after release
        wr_reg(REG_PEND_LO, 16'hFFFF);
        wr_reg(REG_CTRL, 16'h0003);
        switch_i = 24'h00_0F00;
        idle(12);
        rd_chk("frz_lo", REG_STAT_LO, 16'h121D);
        rd_chk("frz_hi", REG_STAT_HI, 16'h00A5);
        wr_reg(REG_CTRL, 16'h0001);
        rd_chk("unfrz_edge1", REG_STAT_LO, 16'h121D);
        rd_chk("unfrz_lo", REG_STAT_LO, 16'h0F00);
        rd_chk("unfrz_hi", REG_STAT_HI, 16'h0000);
        rd_chk("unfrz_pend_lo", REG_PEND_LO, 16'h1D1D);
        rd_chk("unfrz_pend_hi", REG_PEND_HI, 16'h00A5);
        rd_chk("ctrl_rd", REG_CTRL, 16'h0001);
        chk_irq("unfrz_irq", 1'b1);

        // Reserved register and read-during-write
        wr_reg(REG_RSVD, 16'hFFFF);
        rd_chk("rsvd_rd", REG_RSVD, 16'h0000);
        cyc(1'b1, 1'b1, REG_MASK_LO, 16'h00AA);
        check("rdw_old", switchrdata, 16'h0001);
        rd_chk("rdw_new", REG_MASK_LO, 16'h00AA);

        // Reset in the middle of a debounce
        switch_i = 24'h00_00F0;
        idle(3);
        do_reset();
        chk_irq("mid_rst_irq", 1'b0);
        idle(DEB + 2);
        rd_chk("mid_rst_old", REG_STAT_LO, 16'h0000);
        rd_chk("mid_rst_new", REG_STAT_LO, 16'h00F0);
        rd_chk("mid_rst_pend", REG_PEND_LO, 16'h00F0);
        rd_chk("mid_rst_mask", REG_MASK_LO, 16'h0000);

        // Randomized traffic against the model
        switch_i = '0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) switch_i = switch_i ^ (24'd1 << $urandom_range(23));
            if ($urandom_range(40) == 0) switch_i = 24'($urandom);
            r_b = 1'($urandom_range(1));
            w_b = ($urandom_range(5) == 0);
            a   = 3'($urandom_range(7));
            wd  = 16'($urandom);
            if (a == REG_CTRL && $urandom_range(3) != 0) wd[1] = 1'b0;
            cyc(r_b, w_b, a, wd);
            check("rand_rdata", switchrdata, m_rdata);
            chk_irq("rand_irq", m_irq);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
